nios_multi_timer: RTL and testbench
===================================

# nios_multi_timer

Multi-channel Avalon-MM interval timer for the Nios system, the parametrised successor of the single-channel 16-bit-bus timer. It provides NUM_CH independent down-counters of CNT_W bits behind one slave port. Each channel has one-shot or continuous mode, a snapshot register and a sticky timeout flag. All channel interrupts combine into one level IRQ, with a per-channel pending register the ISR reads in one access.

## Interface
- NUM_CH, 4: number of channels, 1..8
- CNT_W, 32: counter/period width, 8..32
- RESET_PERIOD, 49999: reset value of every channel's PERIOD and counter (truncated to CNT_W)
- clk  in  1  system clock
- reset_n  in  1  reset reset_n, asynchronous, active-low; clock clk
- address  in  ADDR_W = clog2(NUM_CH)+2  word address; [ADDR_W-1:2] = channel, [1:0] = register
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe, single cycle
- writedata  in  32  write data
- readdata  out  32  registered read data
- irq  out  1  OR over channels of (TO & ITO)
- irq_pending  out  NUM_CH  per-channel TO & ITO, also readable

## Operation
- Per-channel registers (offset): 0 STATUS {RUN[1], TO[0]}, write any value clears TO; 1 CONTROL {PRESCALE[15:8], STOP[3], START[2], CONT[1], ITO[0]}; 2 PERIOD[CNT_W-1:0]; 3 SNAPSHOT[CNT_W-1:0], write captures counter, read returns capture.
- Channel NUM_CH..max address decode: reads return pending vector zero-extended; writes ignored.
- START/STOP are write-only strobes and read back 0. START and STOP in the same write: start wins.
- A tick is every clk, or every PRESCALE+1 clk with prescaler.
- While RUN, each tick decrements the counter. A tick at count 0 sets TO, reloads PERIOD, and clears RUN unless CONT=1.
- A PERIOD write loads the counter next cycle, clears RUN and resets the prescaler.
- A STATUS clear in the same cycle as a timeout event leaves TO set, so no events are lost.
- Unused high bits read 0. Writes to bits above CNT_W are ignored.
- Reset values: counter = PERIOD = RESET_PERIOD; CONTROL = 0; RUN = TO = 0; snapshot = 0; readdata = 0; irq = 0; irq_pending = 0.
- Reset mid-count aborts immediately and returns all channels to reset values.

## Timing
- Read latency 1 cycle: readdata is valid on the edge after chipselect. There is no waitrequest.
- Write takes effect at the clock edge where chipselect & ~write_n.
- START written at edge 0 sets RUN at edge 0, and the first decrement happens at edge 1.
- Without prescaler, TO rises (P+1) cycles after RUN rises, then every P+1 cycles in CONT mode. With prescaler the interval is (P+1)·(PRESCALE+1).
- P = 0 in CONT mode gives TO every tick.
- irq follows TO/ITO combinationally from registers, so it asserts in the same cycle TO sets.
- Snapshot captures the counter value before that edge's decrement.

## Configuration
- NIOS_TIMER_PRESCALE_EN defined:
  - adds an 8-bit prescaler per channel, controlled by CONTROL[15:8];
  - the prescaler count restarts on START and on PERIOD write.
- Undefined:
  - tick equals every clk;
  - CONTROL[15:8] reads 0 and writes are ignored;
  - no prescaler logic is synthesised.

## Structure
- Package nios_timer_pkg holds:
  - register offsets (REG_STATUS/CONTROL/PERIOD/SNAP);
  - CONTROL bit indices;
  - the control-register struct typedef.
- Sub-module nios_timer_channel (one per channel, generate loop) holds counter, prescaler, RUN/TO, snapshot and CONTROL.
- The top level holds address decode, read mux, readdata register and the IRQ OR.

## Test plan
- Reset → readdata 0, irq 0; ch0 PERIOD reads 49999, STATUS reads 0.
- ch1 PERIOD=9, CONTROL=0x3 (ITO, CONT), START → TO/irq rise 10 cycles after RUN, then every 10 cycles; STATUS write clears irq.
- ch2 one-shot PERIOD=4, START → single TO after 5 cycles, RUN=0, counter reloaded to 4 and held.
- STATUS clear issued in the exact cycle of a timeout (ch0 CONT, P=3) → TO remains 1.
- CONTROL write with START|STOP → RUN=1. PERIOD write while running → RUN=0, counter = new value next cycle.
- With NIOS_TIMER_PRESCALE_EN, PRESCALE=3, P=1 → TO every 8 cycles. Without the macro, same writes give TO every 2 cycles and CONTROL reads 0x00000003.

Source files
------------

// File: rtl/nios_timer_pkg.sv
// Shared definitions for the multi-channel Nios interval timer.
// Holds the per-channel register offsets, CONTROL/STATUS bit indices and the
// stored-control struct used by nios_timer_channel.
package nios_timer_pkg;

  // Register offsets inside one channel's 4-word window
  localparam logic [1:0] REG_STATUS  = 2'd0;
  localparam logic [1:0] REG_CONTROL = 2'd1;
  localparam logic [1:0] REG_PERIOD  = 2'd2;
  localparam logic [1:0] REG_SNAP    = 2'd3;

  // CONTROL bit indices
  localparam int CTRL_ITO    = 0;
  localparam int CTRL_CONT   = 1;
  localparam int CTRL_START  = 2;
  localparam int CTRL_STOP   = 3;
  localparam int CTRL_PS_LSB = 8;
  localparam int CTRL_PS_MSB = 15;

  // STATUS bit indices
  localparam int STAT_TO  = 0;
  localparam int STAT_RUN = 1;

  // Stored part of CONTROL; START/STOP are strobes and never stored
  typedef struct packed {
    logic [7:0] prescale;
    logic       cont;
    logic       ito;
  } ctrl_t;

endpackage

// File: rtl/nios_timer_channel.sv
// One interval-timer channel: down-counter, optional prescaler, RUN/TO flags,
// snapshot register and stored CONTROL.
// Optional feature macro: NIOS_TIMER_PRESCALE_EN (8-bit prescaler in
// CONTROL[15:8]); when undefined every clk is a tick and PRESCALE reads 0.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   wr_en          write strobe already decoded for this channel
//   reg_sel        register offset (STATUS/CONTROL/PERIOD/SNAP)
//   writedata      bus write data
//   rd_data        combinational read value of the selected register
//   pending        TO & ITO, this channel's interrupt request
module nios_timer_channel
  import nios_timer_pkg::*;
#(
  parameter int          CNT_W        = 32,
  parameter logic [31:0] RESET_PERIOD = 32'd49999
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_en,
  input  logic [1:0]  reg_sel,
  input  logic [31:0] writedata,
  output logic [31:0] rd_data,
  output logic        pending
);

  localparam logic [CNT_W-1:0] RST_P = RESET_PERIOD[CNT_W-1:0];

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] snap_q;
  ctrl_t            ctrl_q;
  logic             run_q;
  logic             to_q;

  logic wr_status, wr_control, wr_period, wr_snap;
  logic start, stop;
  logic tick, timeout;
  logic unused_wd;

  assign wr_status  = wr_en && (reg_sel == REG_STATUS);
  assign wr_control = wr_en && (reg_sel == REG_CONTROL);
  assign wr_period  = wr_en && (reg_sel == REG_PERIOD);
  assign wr_snap    = wr_en && (reg_sel == REG_SNAP);
  assign start      = wr_control && writedata[CTRL_START];
  assign stop       = wr_control && writedata[CTRL_STOP];

  // Bits above CNT_W (and PRESCALE when disabled) are intentionally dropped
  assign unused_wd = ^writedata;

`ifdef NIOS_TIMER_PRESCALE_EN
  logic [7:0] presc_q;

  // '>=' so lowering PRESCALE mid-interval cannot strand the count above it
  assign tick = (presc_q >= ctrl_q.prescale);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                presc_q <= 8'd0;
    else if (wr_period || start) presc_q <= 8'd0;
    else if (run_q)              presc_q <= tick ? 8'd0 : presc_q + 8'd1;
  end
`else
  assign tick = 1'b1;
`endif

  assign timeout = run_q && tick && (count_q == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q  <= RST_P;
      period_q <= RST_P;
      snap_q   <= '0;
      ctrl_q   <= '0;
      run_q    <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      if (wr_period) begin
        period_q <= writedata[CNT_W-1:0];
        count_q  <= writedata[CNT_W-1:0];
      end else if (timeout) begin
        count_q  <= period_q;
      end else if (run_q && tick) begin
        count_q  <= count_q - CNT_W'(1);
      end

      // PERIOD write stops the channel; START beats STOP in one write
      if (wr_period)    run_q <= 1'b0;
      else if (start)   run_q <= 1'b1;
      else if (stop)    run_q <= 1'b0;
      else if (timeout) run_q <= ctrl_q.cont;

      // A timeout coinciding with a clear wins so the event is not lost
      if (timeout)        to_q <= 1'b1;
      else if (wr_status) to_q <= 1'b0;

      if (wr_control) begin
        ctrl_q.ito  <= writedata[CTRL_ITO];
        ctrl_q.cont <= writedata[CTRL_CONT];
`ifdef NIOS_TIMER_PRESCALE_EN
        ctrl_q.prescale <= writedata[CTRL_PS_MSB:CTRL_PS_LSB];
`else
        ctrl_q.prescale <= 8'd0;
`endif
      end

      // Captures the pre-decrement value of this edge
      if (wr_snap) snap_q <= count_q;
    end
  end

  always_comb begin
    rd_data = '0;
    case (reg_sel)
      REG_STATUS:  rd_data = {30'd0, run_q, to_q};
      REG_CONTROL: rd_data = {16'd0, ctrl_q.prescale, 6'd0, ctrl_q.cont, ctrl_q.ito};
      REG_PERIOD:  rd_data = 32'(period_q);
      REG_SNAP:    rd_data = 32'(snap_q);
      default:     rd_data = '0;
    endcase
  end

  assign pending = to_q & ctrl_q.ito;

endmodule

// File: rtl/nios_multi_timer.sv
// Multi-channel Avalon-MM interval timer: NUM_CH channels of CNT_W-bit
// down-counters behind one slave port, combined level IRQ.
// Optional feature macro: NIOS_TIMER_PRESCALE_EN (per-channel prescaler).
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   address        word address: [ADDR_W-1:2] channel, [1:0] register
//   chipselect     slave select
//   write_n        active-low write strobe
//   writedata      write data
//   readdata       registered read data (1-cycle latency)
//   irq            OR of all channels' TO & ITO
//   irq_pending    per-channel TO & ITO
// Bus protocol: a transfer is any cycle with chipselect high; write_n low
// makes it a write applied at that edge, write_n high a read whose data
// appears on readdata after that edge. There is no waitrequest, so every
// transfer completes in the cycle it is presented.
module nios_multi_timer
  import nios_timer_pkg::*;
#(
  parameter int          NUM_CH       = 4,
  parameter int          CNT_W        = 32,
  parameter logic [31:0] RESET_PERIOD = 32'd49999,
  localparam int         ADDR_W       = $clog2(NUM_CH) + 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq,
  output logic [NUM_CH-1:0] irq_pending
);

  logic [31:0] ch_idx;
  logic [31:0] ch_rd [NUM_CH];
  logic [31:0] rd_mux;
  logic        bus_wr;

  assign ch_idx = 32'(address >> 2);
  assign bus_wr = chipselect && !write_n;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    nios_timer_channel #(
      .CNT_W        (CNT_W),
      .RESET_PERIOD (RESET_PERIOD)
    ) u_ch (
      .clk       (clk),
      .reset_n   (reset_n),
      .wr_en     (bus_wr && (ch_idx == 32'(i))),
      .reg_sel   (address[1:0]),
      .writedata (writedata),
      .rd_data   (ch_rd[i]),
      .pending   (irq_pending[i])
    );
  end

  // Unpopulated channel slots read back the pending vector
  always_comb begin
    rd_mux = 32'(irq_pending);
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_idx == 32'(i)) rd_mux = ch_rd[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                     readdata <= '0;
    else if (chipselect && write_n)   readdata <= rd_mux;
  end

  assign irq = |irq_pending;

endmodule

// File: tb/tb_nios_multi_timer.sv
// Self-checking bench for nios_multi_timer (default parameters). Expected
// timeout edges come from the interval rule (P+1)*(PRESCALE+1) counted from
// the START edge; register values come from constants and the values written.
module tb_nios_multi_timer;

  localparam int NUM_CH = 4;
  localparam int ADDR_W = 4;
`ifdef NIOS_TIMER_PRESCALE_EN
  localparam bit PS_EN = 1'b1;
`else
  localparam bit PS_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [ADDR_W-1:0] address = '0;
  logic              chipselect = 1'b0;
  logic              write_n = 1'b1;
  logic [31:0]       writedata = '0;
  logic [31:0]       readdata;
  logic              irq;
  logic [NUM_CH-1:0] irq_pending;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nios_multi_timer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .address     (address),
    .chipselect  (chipselect),
    .write_n     (write_n),
    .writedata   (writedata),
    .readdata    (readdata),
    .irq         (irq),
    .irq_pending (irq_pending)
  );

  // ---------------- reference model ----------------
  function automatic int interval(input int p, input int ps);
    return (p + 1) * ((PS_EN ? ps : 0) + 1);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic bus_write(input int ch, input int rg, input logic [31:0] d,
                           output int edge_at);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = ADDR_W'(ch * 4 + rg); writedata = d;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
    edge_at = cyc;
  endtask

  task automatic bus_read(input int ch, input int rg, output logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b1; address = ADDR_W'(ch * 4 + rg);
    @(posedge clk); #1;
    chipselect = 1'b0;
    d = readdata;
  endtask

  // Returns the edge index at which irq is first seen high, or -1
  task automatic wait_irq(input int bound, output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk); #1;
      if (irq) begin
        at = cyc;
        return;
      end
    end
  endtask

  // Continuous run on one channel: n timeouts at start + k*interval
  task automatic run_cont(input int ch, input int p, input int ps, input int n);
    int e0, at, iv, dummy;
    logic [31:0] rd;
    iv = interval(p, ps);
    bus_write(ch, 2, 32'(p), dummy);
    bus_write(ch, 1, 32'h7 | (32'(ps) << 8), e0);
    for (int k = 1; k <= n; k++) begin
      wait_irq(iv + 4, at);
      checks++;
      if (at !== e0 + k * iv) begin
        errors++;
        $display("FAIL cont_to_edge ch%0d p=%0d ps=%0d k=%0d: got edge %0d expected %0d",
                 ch, p, ps, k, at, e0 + k * iv);
      end
      checks++;
      if (irq_pending !== NUM_CH'(1 << ch)) begin
        errors++;
        $display("FAIL irq_pending ch%0d: got %b expected %b", ch, irq_pending, NUM_CH'(1 << ch));
      end
      if (k < n) begin
        bus_write(ch, 0, 32'h0, dummy);
        checks++;
        if (irq !== 1'b0) begin
          errors++;
          $display("FAIL status_clear_irq ch%0d: got %b expected 0", ch, irq);
        end
      end else begin
        bus_write(ch, 1, 32'h8, dummy);
        bus_write(ch, 0, 32'h0, dummy);
        bus_read(ch, 0, rd);
        checks++;
        if (rd !== 32'h0) begin
          errors++;
          $display("FAIL stopped_status ch%0d: got %h expected 0", ch, rd);
        end
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] rd;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (readdata !== 32'h0 || irq !== 1'b0 || irq_pending !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rd=%h irq=%b pend=%b expected 0/0/0",
               readdata, irq, irq_pending);
    end
    @(negedge clk); reset_n = 1'b1;
    bus_read(0, 2, rd);
    checks++;
    if (rd !== 32'd49999) begin errors++; $display("FAIL reset_period0: got %0d expected 49999", rd); end
    bus_read(0, 0, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL reset_status0: got %h expected 0", rd); end
    bus_read(0, 1, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL reset_control0: got %h expected 0", rd); end
    bus_read(0, 3, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL reset_snap0: got %h expected 0", rd); end
    bus_read(3, 2, rd);
    checks++;
    if (rd !== 32'd49999) begin errors++; $display("FAIL reset_period3: got %0d expected 49999", rd); end
  endtask

  task automatic test_continuous();
    run_cont(1, 9, 0, 3);
  endtask

  task automatic test_oneshot();
    int e0, at, dummy;
    logic [31:0] rd;
    bus_write(2, 2, 32'd4, dummy);
    bus_write(2, 1, 32'h5, e0);
    wait_irq(12, at);
    checks++;
    if (at !== e0 + 5) begin errors++; $display("FAIL oneshot_edge: got %0d expected %0d", at, e0 + 5); end
    bus_read(2, 0, rd);
    checks++;
    if (rd !== 32'h1) begin errors++; $display("FAIL oneshot_status: got %h expected 1", rd); end
    bus_write(2, 3, 32'h0, dummy);
    bus_read(2, 3, rd);
    checks++;
    if (rd !== 32'd4) begin errors++; $display("FAIL oneshot_snap: got %0d expected 4", rd); end
    repeat (6) @(posedge clk);
    bus_write(2, 3, 32'h0, dummy);
    bus_read(2, 3, rd);
    checks++;
    if (rd !== 32'd4) begin errors++; $display("FAIL oneshot_held: got %0d expected 4", rd); end
    bus_write(2, 0, 32'h0, dummy);
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL oneshot_no_retrigger: got %b expected 0", irq); end
  endtask

  task automatic test_clear_race();
    int e0, at, dummy;
    logic [31:0] rd;
    bus_write(0, 2, 32'd3, dummy);
    bus_write(0, 1, 32'h7, e0);
    while (cyc < e0 + 3) begin @(posedge clk); #1; end
    bus_write(0, 0, 32'h0, at);
    checks++;
    if (at !== e0 + 4 || irq !== 1'b1) begin
      errors++;
      $display("FAIL clear_race_irq: got edge %0d irq %b expected edge %0d irq 1", at, irq, e0 + 4);
    end
    bus_read(0, 0, rd);
    checks++;
    if (rd !== 32'h3) begin errors++; $display("FAIL clear_race_status: got %h expected 3", rd); end
    bus_write(0, 1, 32'h8, dummy);
    bus_write(0, 0, 32'h0, dummy);
  endtask

  task automatic test_start_stop_period();
    int e0, at, dummy;
    logic [31:0] rd;
    bus_write(3, 2, 32'd20, dummy);
    bus_write(3, 1, 32'hC, dummy);
    bus_read(3, 0, rd);
    checks++;
    if (rd !== 32'h2) begin errors++; $display("FAIL start_wins: got %h expected 2", rd); end
    bus_write(3, 2, 32'd7, dummy);
    bus_read(3, 0, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL period_stops: got %h expected 0", rd); end
    bus_write(3, 3, 32'h0, dummy);
    bus_read(3, 3, rd);
    checks++;
    if (rd !== 32'd7) begin errors++; $display("FAIL period_loads: got %0d expected 7", rd); end
    bus_write(3, 1, 32'h5, e0);
    wait_irq(12, at);
    checks++;
    if (at !== e0 + 8) begin errors++; $display("FAIL restart_edge: got %0d expected %0d", at, e0 + 8); end
    bus_write(3, 0, 32'h0, dummy);
  endtask

  task automatic test_prescale();
    logic [31:0] rd;
    run_cont(1, 1, 3, 3);
    bus_read(1, 1, rd);
    checks++;
    // last CONTROL write in run_cont was the STOP strobe, so re-arm fields
    if (rd !== 32'h0) begin errors++; $display("FAIL control_after_stop: got %h expected 0", rd); end
    begin
      int dummy;
      bus_write(1, 1, 32'h303, dummy);
      bus_read(1, 1, rd);
      checks++;
      if (rd !== (PS_EN ? 32'h303 : 32'h3)) begin
        errors++;
        $display("FAIL control_readback: got %h expected %h", rd, PS_EN ? 32'h303 : 32'h3);
      end
      bus_write(1, 1, 32'h0, dummy);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd;
    for (int it = 0; it < 5; it++) begin
      int ch, p, ps;
      ch = $urandom_range(0, NUM_CH - 1);
      p  = $urandom_range(1, 12);
      ps = $urandom_range(0, 3);
      run_cont(ch, p, ps, 2);
      bus_read(ch, 2, rd);
      checks++;
      if (rd !== 32'(p)) begin errors++; $display("FAIL rand_period ch%0d: got %0d expected %0d", ch, rd, p); end
    end
  endtask

  task automatic test_reset_midcount();
    int dummy;
    logic [31:0] rd;
    bus_write(0, 2, 32'd100, dummy);
    bus_write(0, 1, 32'h7, dummy);
    bus_read(0, 1, rd);
    repeat (20) @(posedge clk);
    @(negedge clk); reset_n = 1'b0;
    #2;
    checks++;
    if (readdata !== 32'h0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got rd=%h irq=%b expected 0/0", readdata, irq);
    end
    @(negedge clk); reset_n = 1'b1;
    bus_read(0, 0, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL reset_mid_status: got %h expected 0", rd); end
    bus_read(0, 2, rd);
    checks++;
    if (rd !== 32'd49999) begin errors++; $display("FAIL reset_mid_period: got %0d expected 49999", rd); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_continuous();
    test_oneshot();
    test_clear_race();
    test_start_stop_period();
    test_prescale();
    test_random();
    test_reset_midcount();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
